// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle signed/unsigned magnitude comparator. The two operands are
// latched on an accepted start. They are then compared CHUNK bits per clock,
// starting with the most significant slice. The first slice that differs
// decides the result. With EARLY_EXIT=1 the compare stops at that slice.
// With EARLY_EXIT=0 all N = WIDTH/CHUNK slices are always scanned, which
// gives a fixed latency.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset (aborts a running compare)
//   start        request, accepted only while idle
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled w/ start)
//   a, b         WIDTH-bit operands (sampled with start)
//   busy         high while a compare is in progress
//   done         single-cycle pulse, g/l/e valid from this cycle
//   g, l, e      one-hot result A>B / A<B / A==B, held until the next done
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  // Reject parameter combinations that cannot be sliced evenly.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(N - 1);
  localparam logic [IDXW-1:0]  ZERO_IDX  = {IDXW{1'b0}};
  localparam logic [CHUNK-1:0] MSB_MASK  = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              signed_r;
  logic [IDXW-1:0]   idx_r;
  logic              found_r;   // a differing slice has already been seen
  logic              gt_r;      // its direction (1 = A greater)

  logic [31:0]       shamt_s;
  logic [CHUNK-1:0]  flip_s;
  logic [CHUNK-1:0]  a_slice_s;
  logic [CHUNK-1:0]  b_slice_s;
  logic              differ_s;
  logic              slice_gt_s;
  logic              found_next_s;
  logic              gt_next_s;
  logic              last_s;
  logic              exit_s;

  // Current slice extraction and per-slice compare / exit decision.
  always_comb begin
    // Slice idx sits (N-1-idx) slices above the LSB. Shift it down and truncate.
    shamt_s   = 32'(LAST_IDX - idx_r) * 32'(CHUNK);
    a_slice_s = CHUNK'(a_r >> shamt_s);
    b_slice_s = CHUNK'(b_r >> shamt_s);

    // Offset-binary trick: flipping the sign bit of both operands turns a
    // two's-complement order into an unsigned order. Only the top slice
    // holds the sign bit.
    if (signed_r && (idx_r == ZERO_IDX)) begin
      flip_s = MSB_MASK;
    end else begin
      flip_s = {CHUNK{1'b0}};
    end

    differ_s   = ((a_slice_s ^ flip_s) != (b_slice_s ^ flip_s));
    slice_gt_s = ((a_slice_s ^ flip_s) >  (b_slice_s ^ flip_s));

    // A pending result from a more significant slice always wins.
    found_next_s = found_r | differ_s;
    if (found_r) begin
      gt_next_s = gt_r;
    end else begin
      gt_next_s = slice_gt_s;
    end

    last_s = (idx_r == LAST_IDX);
    exit_s = last_s | (EARLY_EXIT & differ_s);
  end

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      signed_r <= 1'b0;
      idx_r    <= ZERO_IDX;
      found_r  <= 1'b0;
      gt_r     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      g        <= 1'b0;
      l        <= 1'b0;
      e        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= signed_mode;
            idx_r    <= ZERO_IDX;
            found_r  <= 1'b0;
            gt_r     <= 1'b0;
            busy     <= 1'b1;
            state_r  <= CMP;
          end else begin
            state_r  <= IDLE;
          end
        end
        CMP: begin
          // Any start seen here is dropped, because only IDLE samples start.
          if (exit_s) begin
            g       <= found_next_s &  gt_next_s;
            l       <= found_next_s & ~gt_next_s;
            e       <= ~found_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            found_r <= found_next_s;
            gt_r    <= gt_next_s;
            idx_r   <= idx_r + IDXW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
